vga_timing_gen: RTL
===================

// Module: vga_timing_gen
// PURPOSE
//   Raster timing generator for the 640x480@60 Hz VGA path. It runs from the 50 MHz board clock.
//   It makes an internal 25 MHz pixel enable and drives pixel/line counters, sync pulses and the
//   active-area flag. The border/colour stage directly downstream consumes these outputs.
//   It is the single timing source: downstream logic registers on clk, qualified by pixel_tick.
// PARAMETERS
//   H_DISPLAY  640  visible pixels per line
//   H_FRONT    16   horizontal front porch (pixels)
//   H_SYNC     96   horizontal sync width (pixels)
//   H_BACK     48   horizontal back porch (pixels); line total = 800
//   V_DISPLAY  480  visible lines per frame
//   V_FRONT    10   vertical front porch (lines)
//   V_SYNC     2    vertical sync width (lines)
//   V_BACK     33   vertical back porch (lines); frame total = 525
// PORTS
//   clk              in   1   50 MHz system clock
//   reset            in   1   asynchronous, active-low reset
//   pixel_tick       out  1   1-clk pulse every 2nd clk (25 MHz pixel enable)
//   h_count          out  10  current pixel column, 0..799
//   v_count          out  10  current line, 0..524
//   horizontal_sync  out  1   active-low horizontal sync
//   vertical_sync    out  1   active-low vertical sync
//   display_en       out  1   1 when h_count<H_DISPLAY and v_count<V_DISPLAY
//   frame_start      out  1   1-clk pulse on the edge counters wrap to (0,0)
//   frame_count      out  8   frames since reset (only with VGA_FRAME_CNT_EN)
// BEHAVIOUR
//   - Reset (reset=0, async): pixel_tick=0, h_count=799, v_count=524, horizontal_sync=1,
//     vertical_sync=1, display_en=0, frame_start=0, frame_count=0.
//     The counters sit at the last position of a frame, so the first advance lands on (0,0).
//   - pixel_tick: toggle flop. The first clk edge after reset release sets it to 1, then 0,1,0,...
//   - Counters advance on a clk edge where pixel_tick==1 (pixel rate = clk/2).
//     h_count: 799 wraps to 0; otherwise +1.
//     v_count: +1 only when h_count wraps; 524 wraps to 0; otherwise holds.
//   - All outputs are registered. Sync and display flags are decoded from the next-count values
//     and update on the same edge as the counters, so they are always aligned with
//     h_count/v_count (zero relative latency).
//   - horizontal_sync=0 iff H_DISPLAY+H_FRONT <= h_count < H_DISPLAY+H_FRONT+H_SYNC (656..751).
//   - vertical_sync=0 iff V_DISPLAY+V_FRONT <= v_count < V_DISPLAY+V_FRONT+V_SYNC (490..491).
//   - frame_start=1 for exactly one clk: the edge where the counters go from (799,524) to (0,0).
//     Deasserts the following clk.
//   - Outputs hold their value on clk edges where pixel_tick==0 (except frame_start, which clears).
//   - Reset asserted mid-frame: all outputs return to their reset values immediately (async).
//     Timing restarts cleanly from (0,0) two clks after release. No partial sync pulse survives.
//   - Counter widths are 10 bits. Parameter sums must stay <= 1023; this is not checked in RTL.
// CONFIGURATION
//   `VGA_FRAME_CNT_EN defined: frame_count port exists.
//     It increments by 1 on each frame_start and wraps 255 -> 0. Reset value is 0.
//   `VGA_FRAME_CNT_EN undefined: no frame_count port and no counter logic.
//     All other behaviour is identical.
// TESTING
//   1. Hold reset=0 for 5 clk -> h_count=799, v_count=524, both syncs=1, display_en=0,
//      pixel_tick=0, frame_start=0.
//   2. Release reset -> first advance gives (0,0) with display_en=1 and frame_start=1 for 1 clk.
//      pixel_tick then alternates 1,0.
//   3. Run one line -> 1600 clk between h_count==0 occurrences.
//      horizontal_sync low for exactly 96 ticks (192 clk), starting at h_count=656.
//      display_en high for 640 ticks per visible line.
//   4. Run one full frame -> 525 lines, 840000 clk between frame_start pulses.
//      vertical_sync low for lines 490-491 only. display_en never 1 for v_count>=480.
//   5. Assert reset at (320,200) mid-line -> outputs return to reset values on the same edge.
//      After release the sequence matches scenario 2.
//   6. With VGA_FRAME_CNT_EN, run 257 frames -> frame_count goes 0..255, then 0, then 1.
//      Without the macro, the build elaborates with no frame_count port.

Source files
------------

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - 640x480@60 raster timing generator: 25 MHz pixel enable from 50 MHz clk, counters, syncs, active flag.
// Optional frame counter output is built only when VGA_FRAME_CNT_EN is defined.
module vga_timing_gen #(
    parameter int unsigned H_DISPLAY = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_DISPLAY = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33
) (
    input  logic       clk,
    input  logic       reset,
    output logic       pixel_tick,
    output logic [9:0] h_count,
    output logic [9:0] v_count,
    output logic       horizontal_sync,
    output logic       vertical_sync,
    output logic       display_en,
    output logic       frame_start
`ifdef VGA_FRAME_CNT_EN
    ,
    output logic [7:0] frame_count
`endif
);

    localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT    = 10'(H_DISPLAY);
    localparam logic [9:0] V_ACT    = 10'(V_DISPLAY);
    localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC);

    logic [9:0] h_next;
    logic [9:0] v_next;
    logic       h_wrap;
    logic       v_wrap;
    logic       frame_wrap;

    always_comb begin
        h_wrap     = (h_count == H_LAST);
        v_wrap     = (v_count == V_LAST);
        frame_wrap = h_wrap && v_wrap;
        h_next     = h_wrap ? 10'd0 : h_count + 10'd1;
        v_next     = v_count;
        if (h_wrap) begin
            v_next = v_wrap ? 10'd0 : v_count + 10'd1;
        end
    end

    // Flags decode from the next-count values so they land on the same edge as the counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pixel_tick      <= 1'b0;
            h_count         <= H_LAST;
            v_count         <= V_LAST;
            horizontal_sync <= 1'b1;
            vertical_sync   <= 1'b1;
            display_en      <= 1'b0;
            frame_start     <= 1'b0;
        end else begin
            pixel_tick  <= ~pixel_tick;
            frame_start <= 1'b0;
            if (pixel_tick) begin
                h_count         <= h_next;
                v_count         <= v_next;
                horizontal_sync <= !((h_next >= HS_START) && (h_next < HS_END));
                vertical_sync   <= !((v_next >= VS_START) && (v_next < VS_END));
                display_en      <= (h_next < H_ACT) && (v_next < V_ACT);
                frame_start     <= frame_wrap;
            end
        end
    end

`ifdef VGA_FRAME_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_count <= 8'd0;
        end else if (pixel_tick && frame_wrap) begin
            frame_count <= frame_count + 8'd1;
        end
    end
`endif

endmodule
